// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared types and constants for the CP0 exception sequencer
package cp0_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ENTER,
    ST_SERVICE,
    ST_RETURN
  } exc_state_t;

  localparam logic [1:0] SEL_EPC    = 2'b00;
  localparam logic [1:0] SEL_STATUS = 2'b01;
  localparam logic [1:0] SEL_MASK   = 2'b10;
  localparam logic [1:0] SEL_CAUSE  = 2'b11;

  localparam logic [31:0] CAUSE_SRC0 = 32'd1;
  localparam logic [31:0] CAUSE_SRC1 = 32'd3;
  localparam logic [31:0] CAUSE_SRC2 = 32'd7;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0004;

  // Source k reports 2^(k+1)-1, so higher sources set a superset of bits.
  function automatic logic [31:0] cause_code(input logic [31:0] k);
    return (32'd2 << k) - 32'd1;
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - pipeline handshake, request lines and CP0 access bus
interface exc_ctrl_if #(
  parameter int NSRC = 3
) ();
  logic [NSRC-1:0] irq;
  logic [31:0]     pc_in;
  logic            pipe_ack;
  logic            eret;
  logic            cp0_we;
  logic [1:0]      cp0_sel;
  logic [31:0]     cp0_wdata;
  logic [31:0]     cp0_rdata;
  logic            exc_req;
  logic            redirect;
  logic [31:0]     redirect_pc;
  logic            in_service;
  logic [NSRC-1:0] irq_ack;

  modport master (
    output irq, pc_in, pipe_ack, eret, cp0_we, cp0_sel, cp0_wdata,
    input  cp0_rdata, exc_req, redirect, redirect_pc, in_service, irq_ack
  );

  modport slave (
    input  irq, pc_in, pipe_ack, eret, cp0_we, cp0_sel, cp0_wdata,
    output cp0_rdata, exc_req, redirect, redirect_pc, in_service, irq_ack
  );
endinterface

// File: rtl/exc_ctrl_prio_arb.sv
// rtl/exc_ctrl_prio_arb.sv - combinational fixed-priority pick, highest index wins
module prio_arb #(
  parameter int NSRC = 3,
  parameter int IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0] req,
  output logic [NSRC-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception entry/return sequencer and CP0 register file
module exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          NSRC       = 3,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  exc_ctrl_if.slave  bus
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  exc_state_t      state, state_nx;
  logic [31:0]     epc, status, mask, cause;
  logic [NSRC-1:0] pending, irq_q, eligible, grant, ack_c;
  logic [IW-1:0]   win;
  logic            any, take;
  logic            exc_req_c, redirect_c, in_service_c;
  logic [31:0]     redirect_pc_c, rdata_c;
  logic            sw_epc, sw_status, sw_mask, sw_cause;

  assign eligible = pending & mask[NSRC-1:0] & ~{NSRC{status[0]}};

  prio_arb #(.NSRC(NSRC), .IW(IW)) u_arb (
    .req   (eligible),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign sw_epc    = bus.cp0_we && (bus.cp0_sel == SEL_EPC);
  assign sw_status = bus.cp0_we && (bus.cp0_sel == SEL_STATUS);
  assign sw_mask   = bus.cp0_we && (bus.cp0_sel == SEL_MASK);
  assign sw_cause  = bus.cp0_we && (bus.cp0_sel == SEL_CAUSE);

  always_comb begin
    state_nx      = state;
    take          = 1'b0;
    ack_c         = '0;
    exc_req_c     = 1'b0;
    redirect_c    = 1'b0;
    redirect_pc_c = '0;
    in_service_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any) state_nx = ST_REQ;
      end
      ST_REQ: begin
        exc_req_c = 1'b1;
        // A withdrawn request never completes an ack, even if pipe_ack is high.
        if (!any) begin
          state_nx = ST_IDLE;
        end else if (bus.pipe_ack) begin
          take     = 1'b1;
          ack_c    = grant;
          state_nx = ST_ENTER;
        end
      end
      ST_ENTER: begin
        redirect_c    = 1'b1;
        redirect_pc_c = EXC_VECTOR;
        state_nx      = ST_SERVICE;
      end
      ST_SERVICE: begin
        in_service_c = 1'b1;
        if (bus.eret) state_nx = ST_RETURN;
      end
      ST_RETURN: begin
        redirect_c    = 1'b1;
        redirect_pc_c = epc;
        state_nx      = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      epc     <= '0;
      status  <= '0;
      mask    <= '0;
      cause   <= '0;
      pending <= '0;
      irq_q   <= '0;
    end else begin
      state   <= state_nx;
      irq_q   <= bus.irq;
      pending <= (pending & ~ack_c) | (bus.irq & ~irq_q);
      if (sw_mask) mask <= bus.cp0_wdata;
      // Hardware capture overrides a coincident mtc0 to the same register.
      if (take)        epc <= bus.pc_in;
      else if (sw_epc) epc <= bus.cp0_wdata;
      if (take)          cause <= cause_code(32'(win));
      else if (sw_cause) cause <= bus.cp0_wdata;
      if (sw_status) status <= bus.cp0_wdata;
      if (take)                       status[0] <= 1'b1;
      else if (state == ST_RETURN)    status[0] <= 1'b0;
    end
  end

  always_comb begin
    rdata_c = '0;
    case (bus.cp0_sel)
      SEL_EPC:    rdata_c = epc;
      SEL_STATUS: rdata_c = status;
      SEL_MASK:   rdata_c = mask;
      SEL_CAUSE:  rdata_c = cause;
      default:    rdata_c = '0;
    endcase
  end

  assign bus.cp0_rdata   = rdata_c;
  assign bus.exc_req     = exc_req_c;
  assign bus.redirect    = redirect_c;
  assign bus.redirect_pc = redirect_pc_c;
  assign bus.in_service  = in_service_c;
  assign bus.irq_ack     = ack_c;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed and randomized checks of exc_ctrl against a behavioural model
module tb_exc_ctrl;
  import cp0_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  exc_ctrl_if #(.NSRC(3)) ifc ();

  exc_ctrl #(.NSRC(3), .EXC_VECTOR(32'h0000_0004)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, want, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 requesting, 2 entering, 3 in handler, 4 returning.
  int          ph;
  logic [2:0]  m_pend, m_prev;
  logic [31:0] m_epc, m_status, m_mask, m_cause;
  logic        prev_red;

  always @(negedge clk) begin : cmp
    logic [2:0]  elig, e_ack;
    logic [31:0] e_rd;
    int          win;
    if (!rst_n) begin
      check("rst_outs", {26'd0, ifc.exc_req, ifc.redirect, ifc.in_service, ifc.irq_ack}, 32'd0);
      check("rst_rdata", ifc.cp0_rdata, 32'd0);
      ph = 0; m_pend = 0; m_prev = 0;
      m_epc = 0; m_status = 0; m_mask = 0; m_cause = 0;
      prev_red = 1'b0;
    end else begin
      elig = m_pend & m_mask[2:0] & (m_status[0] ? 3'b000 : 3'b111);
      win = -1;
      for (int k = 0; k < 3; k++) if (elig[k]) win = k;
      e_ack = (ph == 1 && ifc.pipe_ack && win >= 0) ? 3'(1 << win) : 3'b000;
      case (ifc.cp0_sel)
        2'd0: e_rd = m_epc;
        2'd1: e_rd = m_status;
        2'd2: e_rd = m_mask;
        default: e_rd = m_cause;
      endcase
      check("exc_req", 32'(ifc.exc_req), 32'(ph == 1));
      check("redirect", 32'(ifc.redirect), 32'(ph == 2 || ph == 4));
      check("in_service", 32'(ifc.in_service), 32'(ph == 3));
      check("irq_ack", 32'(ifc.irq_ack), 32'(e_ack));
      check("cp0_rdata", ifc.cp0_rdata, e_rd);
      if (ph == 2) check("redirect_pc_vec", ifc.redirect_pc, 32'h4);
      if (ph == 4) check("redirect_pc_epc", ifc.redirect_pc, m_epc);
      check("redirect_back_to_back", 32'(ifc.redirect & prev_red), 32'd0);
      prev_red = ifc.redirect;

      m_pend = (m_pend & ~e_ack) | (ifc.irq & ~m_prev);
      m_prev = ifc.irq;
      if (ifc.cp0_we) begin
        case (ifc.cp0_sel)
          2'd0: m_epc = ifc.cp0_wdata;
          2'd1: m_status = ifc.cp0_wdata;
          2'd2: m_mask = ifc.cp0_wdata;
          default: m_cause = ifc.cp0_wdata;
        endcase
      end
      if (e_ack != 0) begin
        m_epc = ifc.pc_in;
        m_cause = 32'((1 << (win + 1)) - 1);
        m_status[0] = 1'b1;
      end
      if (ph == 4) m_status[0] = 1'b0;
      case (ph)
        0: ph = (win >= 0) ? 1 : 0;
        1: ph = (win < 0) ? 0 : (ifc.pipe_ack ? 2 : 1);
        2: ph = 3;
        3: ph = ifc.eret ? 4 : 3;
        default: ph = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] s, input logic [31:0] want, input string name);
    ifc.cp0_sel = s;
    #1;
    check(name, ifc.cp0_rdata, want);
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    ifc.cp0_we = 1'b1;
    ifc.cp0_sel = s;
    ifc.cp0_wdata = d;
    tick();
    ifc.cp0_we = 1'b0;
  endtask

  initial begin : stim
    logic [31:0] r;
    rst_n = 1'b0;
    ifc.irq = 0; ifc.pc_in = 0; ifc.pipe_ack = 0; ifc.eret = 0;
    ifc.cp0_we = 0; ifc.cp0_sel = 0; ifc.cp0_wdata = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    rd(SEL_EPC, 0, "init_epc"); rd(SEL_STATUS, 0, "init_status"); rd(SEL_MASK, 0, "init_mask");

    // Basic entry on source 1.
    wr(SEL_MASK, 32'd2);
    ifc.irq = 3'b010;
    tick(); #1 check("basic_no_req_e0", 32'(ifc.exc_req), 0);
    tick(); ifc.pipe_ack = 1; ifc.pc_in = 32'h40;
    #1 check("basic_req", 32'(ifc.exc_req), 1); check("basic_ack", 32'(ifc.irq_ack), 32'b010);
    tick(); ifc.pipe_ack = 0; ifc.irq = 0;
    #1 check("basic_redirect", 32'(ifc.redirect), 1); check("basic_vec", ifc.redirect_pc, 32'h4);
    tick(); #1 check("basic_in_service", 32'(ifc.in_service), 1);
    rd(SEL_EPC, 32'h40, "basic_epc"); rd(SEL_CAUSE, 32'd3, "basic_cause");
    tick(); rd(SEL_STATUS, 32'd1, "basic_status"); ifc.eret = 1;
    tick(); ifc.eret = 0;
    #1 check("basic_ret", 32'(ifc.redirect), 1); check("basic_ret_pc", ifc.redirect_pc, 32'h40);
    tick(); rd(SEL_STATUS, 32'd0, "basic_status_clr");

    // Priority: sources 0 and 2 together.
    wr(SEL_MASK, 32'd7);
    ifc.irq = 3'b101;
    tick(); tick(); ifc.pipe_ack = 1; ifc.pc_in = 32'h80;
    #1 check("prio_ack2", 32'(ifc.irq_ack), 32'b100);
    tick(); ifc.pipe_ack = 0; ifc.irq = 0;
    tick(); rd(SEL_CAUSE, CAUSE_SRC2, "prio_cause7"); ifc.eret = 1;
    tick(); ifc.eret = 0; #1 check("prio_ret_pc", ifc.redirect_pc, 32'h80);
    tick(); rd(SEL_STATUS, 0, "prio_status_gap"); check("prio_gap_noreq", 32'(ifc.exc_req), 0);
    tick(); ifc.pipe_ack = 1; ifc.pc_in = 32'h84;
    #1 check("prio_req0", 32'(ifc.exc_req), 1); check("prio_ack0", 32'(ifc.irq_ack), 32'b001);
    tick(); ifc.pipe_ack = 0;
    tick(); rd(SEL_CAUSE, CAUSE_SRC0, "prio_cause1"); rd(SEL_EPC, 32'h84, "prio_epc2"); ifc.eret = 1;
    tick(); ifc.eret = 0;
    tick();

    // Blocking: a new edge during service waits for return.
    ifc.irq = 3'b100;
    tick(); tick(); ifc.pipe_ack = 1; ifc.pc_in = 32'hC0;
    tick(); ifc.pipe_ack = 0; ifc.irq = 0;
    tick(); ifc.irq = 3'b001;
    tick(); #1 check("blk_noreq1", 32'(ifc.exc_req), 0);
    tick(); #1 check("blk_noreq2", 32'(ifc.exc_req), 0); ifc.eret = 1;
    tick(); ifc.eret = 0;
    tick(); rd(SEL_STATUS, 0, "blk_status_gap"); check("blk_gap_noreq", 32'(ifc.exc_req), 0);
    tick(); ifc.pipe_ack = 1;
    #1 check("blk_req", 32'(ifc.exc_req), 1); check("blk_ack0", 32'(ifc.irq_ack), 32'b001);
    tick(); ifc.pipe_ack = 0; ifc.irq = 0;
    tick(); ifc.eret = 1;
    tick(); ifc.eret = 0;
    tick();

    // Masking, then withdrawal.
    wr(SEL_MASK, 0);
    ifc.irq = 3'b001;
    repeat (3) tick();
    #1 check("mask_noreq", 32'(ifc.exc_req), 0);
    wr(SEL_MASK, 1);
    #1 check("mask_w_noreq", 32'(ifc.exc_req), 0);
    tick(); #1 check("mask_req", 32'(ifc.exc_req), 1);
    wr(SEL_MASK, 0);
    tick(); #1 check("wd_idle", 32'(ifc.exc_req), 0); check("wd_noredir", 32'(ifc.redirect), 0);
    tick(); #1 check("wd_noredir2", 32'(ifc.redirect), 0);

    // Collision: mtc0 EPC on the ack edge loses to the captured pc_in.
    wr(SEL_MASK, 1);
    tick(); ifc.pipe_ack = 1; ifc.pc_in = 32'h200;
    ifc.cp0_we = 1; ifc.cp0_sel = SEL_EPC; ifc.cp0_wdata = 32'h100;
    tick(); ifc.cp0_we = 0; ifc.pipe_ack = 0; ifc.irq = 0;
    rd(SEL_EPC, 32'h200, "coll_epc");
    tick(); ifc.eret = 1;
    tick(); ifc.eret = 0;
    tick();

    // Asynchronous reset while requesting.
    ifc.irq = 3'b001;
    tick(); tick(); #1 check("rst_pre_req", 32'(ifc.exc_req), 1);
    rst_n = 0;
    #1 check("rst_async_req", 32'(ifc.exc_req), 0); check("rst_async_redir", 32'(ifc.redirect), 0);
    ifc.irq = 0;
    tick(); tick(); rst_n = 1;
    tick(); rd(SEL_EPC, 0, "post_epc"); rd(SEL_STATUS, 0, "post_status"); rd(SEL_MASK, 0, "post_mask");
    tick(); rd(SEL_CAUSE, 0, "post_cause"); check("post_noredir", 32'(ifc.redirect), 0);

    // Randomized traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      for (int k = 0; k < 3; k++) if ($urandom_range(0, 7) == 0) ifc.irq[k] = ~ifc.irq[k];
      ifc.pipe_ack = 1'($urandom_range(0, 1));
      ifc.eret = ($urandom_range(0, 3) == 0);
      ifc.pc_in = $urandom & 32'hFFFF_FFFC;
      ifc.cp0_sel = 2'($urandom_range(0, 3));
      ifc.cp0_we = ($urandom_range(0, 9) == 0);
      r = $urandom;
      if (ifc.cp0_sel == SEL_MASK) ifc.cp0_wdata = 32'($urandom_range(0, 7));
      else if (ifc.cp0_sel == SEL_STATUS) ifc.cp0_wdata = {r[31:1], ($urandom_range(0, 3) == 0)};
      else ifc.cp0_wdata = r;
      if ($urandom_range(0, 499) == 0) begin
        ifc.cp0_we = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
      end
    end
    ifc.cp0_we = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer for the MIPS core's coprocessor-0 path. It collects up to three external exception requests and filters them through a software-writable mask and a global block bit. A fixed-priority choice selects one source, and the block handshakes with the pipeline to enter the handler at an instruction boundary, capturing EPC/Cause. On ERET it returns the pipeline to EPC. It also owns the CP0 register file (EPC, Status, Mask, Cause) and its mtc0/mfc0 access.

## Interface
- NSRC, 3, number of exception sources (fixed priority: highest index wins)
- EXC_VECTOR, 32'h0000_0004, handler entry address
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- irq  in  NSRC  request lines, synchronous to clk; a rising edge raises a request
- pc_in  in  32  resume PC offered by the pipeline; sampled when pipe_ack is accepted
- pipe_ack  in  1  pipeline at instruction boundary, accepts exception entry
- eret  in  1  one-cycle pulse, ERET retiring
- cp0_we  in  1  mtc0 write strobe
- cp0_sel  in  2  register select: 00 EPC, 01 Status, 10 Mask, 11 Cause
- cp0_wdata  in  32  mtc0 data
- cp0_rdata  out  32  mfc0 data, combinational from cp0_sel
- exc_req  out  1  exception pending entry, held until ack or withdrawal
- redirect  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  redirect target, valid with redirect
- in_service  out  1  handler active
- irq_ack  out  NSRC  one-hot, one-cycle, source being taken

## Operation
- Edge detect: pending[k] sets when irq[k]=1 and irq_q[k]=0. Clears when source k is taken. A set and a clear on the same cycle resolve to set.
- eligible = pending & Mask[NSRC-1:0] & ~{NSRC{Status[0]}}. Winner is the highest set index; code = 2^(k+1)-1, giving 1, 3 and 7.
- FSM states: IDLE, REQ, ENTER, SERVICE, RETURN.
- IDLE to REQ when eligible is nonzero.
- REQ: exc_req=1 and the winner is re-evaluated every cycle.
  - eligible becoming zero returns to IDLE.
  - pipe_ack=1 goes to ENTER. On that edge: EPC<=pc_in, Cause<=code, Status[0]<=1, pending[win]<=0. irq_ack[win] is asserted in the ack cycle.
- ENTER: redirect=1, redirect_pc=EXC_VECTOR; goes to SERVICE next.
- SERVICE: in_service=1. New edges accumulate in pending. eret goes to RETURN.
- RETURN: redirect=1, redirect_pc=EPC, then IDLE. Status[0]<=0 on the RETURN-to-IDLE edge.
- eret outside SERVICE is ignored.
- Software writes land at posedge when cp0_we=1. A hardware update of Status/EPC/Cause on the same edge wins over the software write.
- Writing Mask or Status in REQ takes effect on eligibility the next cycle.

## Timing
- Reset: FSM IDLE, EPC/Status/Mask/Cause=0, pending=0, irq_q=0. All outputs are 0 asynchronously while rst_n=0.
- Reset mid-operation aborts immediately. No redirect is issued after release.
- Latency from irq edge to redirect:
  - edge E0 registers pending;
  - E1 enters REQ, with exc_req high after E1;
  - if pipe_ack is high in that cycle, E2 enters ENTER and redirect is high in the cycle after E2.
- The minimum is 3 edges. Each cycle of pipe_ack delay adds one.
- eret at cycle n gives redirect to EPC in cycle n+1. Re-entry is earliest at exc_req two cycles after RETURN.
- redirect is never high for two consecutive cycles.

## Structure
- Package cp0_pkg holds:
  - the state enum;
  - the sel codes (SEL_EPC, SEL_STATUS, SEL_MASK, SEL_CAUSE);
  - the cause codes;
  - the default EXC_VECTOR.
- Sub-module prio_arb(NSRC) is combinational fixed-priority. It takes eligible and outputs a one-hot grant, index, and any.

## Test plan
- Reset with rst_n=0 while in REQ: exc_req=0 and redirect=0 at once; cp0_rdata=0 for all four sel values after release.
- Basic entry:
  - stimulus: Mask=3'b010, irq[1] rises, pc_in=0x40, pipe_ack high in the first REQ cycle;
  - response: irq_ack=3'b010, redirect with 0x4 three edges after the irq edge, then EPC=0x40, Cause=3, Status=1, in_service=1.
- Priority: Mask=7 with irq[0] and irq[2] rising together: Cause=7 first. After eret, redirect to EPC, then source 0 is taken with Cause=1.
- Blocking: irq[0] rises in SERVICE and no second exc_req appears. It is taken only after RETURN, and Status reads 0 for one cycle between.
- Masking: Mask=0 with an irq[0] edge gives no exc_req. mtc0 Mask=1 gives exc_req the cycle after the write edge.
- Withdrawal and collision:
  - in REQ without pipe_ack, mtc0 Mask=0 returns the FSM to IDLE with no redirect;
  - mtc0 EPC=0x100 on the ack edge still yields EPC=pc_in.
